// File: rtl/usb_tx_pkg.sv
// Shared constants and types for the USB transmit line encoder.
// Line states are packed as {d_plus, d_minus}.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SYNC      = 3'd1,
      DATA      = 3'd2,
      EOP_SE0_A = 3'd3,
      EOP_SE0_B = 3'd4,
      EOP_J     = 3'd5
   } tx_enc_state_t;

   localparam logic [7:0] SYNC_BYTE    = 8'h80;
   localparam logic [2:0] STUFF_LIMIT  = 3'd6;
   localparam logic [3:0] BIT_ROLLOVER = 4'd8;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   // NRZI level 1 is the J state, 0 is the K state
   function automatic logic [1:0] nrzi_line(input logic level);
      nrzi_line = level ? LINE_J : LINE_K;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic wrapping counter: counts 0 .. rollover_val-1 when enabled, then wraps to 0.
// A synchronous clear has priority over counting.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out
);

   localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   logic [NUM_CNT_BITS-1:0] count_r;
   logic [NUM_CNT_BITS-1:0] count_next_s;

   // next count: clear, wrap at rollover, or increment
   always_comb begin
      count_next_s = count_r;
      if (clear) begin
         count_next_s = '0;
      end else if (count_enable) begin
         if (count_r == (rollover_val - CNT_ONE)) begin
            count_next_s = '0;
         end else begin
            count_next_s = count_r + CNT_ONE;
         end
      end else begin
         count_next_s = count_r;
      end
   end

   // count register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_r <= '0;
      end else begin
         count_r <= count_next_s;
      end
   end

   assign count_out = count_r;

endmodule

// File: rtl/usb_tx_encoder.sv
// Serialises SYNC, payload bytes (LSB first) and EOP onto D+/D- with NRZI
// encoding and bit stuffing, advancing one bit per shift_en strobe.
module usb_tx_encoder
   import usb_tx_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       shift_en,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       byte_ack,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_busy,
   output logic       tx_done
);

   tx_enc_state_t state_r, state_next_s;
   logic [7:0]    shreg_r, shreg_next_s;
   logic [2:0]    ones_r, ones_next_s;
   logic          nrzi_r, nrzi_next_s;
   logic [1:0]    line_r, line_next_s;
   logic          last_r, last_next_s;
   logic          busy_r, busy_next_s;
   logic          ack_r, ack_next_s;
   logic          done_r, done_next_s;
   logic          cnt_clear_s;
   logic          cnt_en_s;
   logic [3:0]    bit_idx_s;
   logic          bit_last_s;
   logic          data_bit_s;

   flex_counter #(
      .NUM_CNT_BITS (4)
   ) u_bit_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (cnt_clear_s),
      .count_enable (cnt_en_s),
      .rollover_val (BIT_ROLLOVER),
      .count_out    (bit_idx_s)
   );

   assign bit_last_s = (bit_idx_s == (BIT_ROLLOVER - 4'd1));
   assign data_bit_s = shreg_r[0];

   // next-state, line and handshake logic
   always_comb begin
      state_next_s = state_r;
      shreg_next_s = shreg_r;
      ones_next_s  = ones_r;
      nrzi_next_s  = nrzi_r;
      line_next_s  = line_r;
      last_next_s  = last_r;
      busy_next_s  = busy_r;
      ack_next_s   = 1'b0;
      done_next_s  = 1'b0;
      cnt_clear_s  = 1'b0;
      cnt_en_s     = 1'b0;

      case (state_r)
         IDLE: begin
            // a coincident strobe is deliberately ignored: the first bit goes out on the next one
            if (tx_start) begin
               shreg_next_s = SYNC_BYTE;
               ones_next_s  = 3'd0;
               cnt_clear_s  = 1'b1;
               busy_next_s  = 1'b1;
               state_next_s = SYNC;
            end else begin
               state_next_s = IDLE;
            end
         end

         SYNC, DATA: begin
            if (!shift_en) begin
               state_next_s = state_r;
            end else if (ones_r == STUFF_LIMIT) begin
               nrzi_next_s = ~nrzi_r;
               line_next_s = nrzi_line(~nrzi_r);
               ones_next_s = 3'd0;
            end else begin
               nrzi_next_s = data_bit_s ? nrzi_r : ~nrzi_r;
               line_next_s = nrzi_line(data_bit_s ? nrzi_r : ~nrzi_r);
               ones_next_s = data_bit_s ? (ones_r + 3'd1) : 3'd0;
               cnt_en_s    = 1'b1;
               if (!bit_last_s) begin
                  shreg_next_s = {1'b0, shreg_r[7:1]};
               end else if ((state_r == SYNC) || !last_r) begin
                  shreg_next_s = tx_data;
                  last_next_s  = tx_last;
                  ack_next_s   = 1'b1;
                  state_next_s = DATA;
               end else begin
                  shreg_next_s = {1'b0, shreg_r[7:1]};
                  state_next_s = EOP_SE0_A;
               end
            end
         end

         EOP_SE0_A: begin
            // trailing run of six ones still needs its stuff bit before SE0
            if (!shift_en) begin
               state_next_s = EOP_SE0_A;
            end else if (ones_r == STUFF_LIMIT) begin
               nrzi_next_s = ~nrzi_r;
               line_next_s = nrzi_line(~nrzi_r);
               ones_next_s = 3'd0;
            end else begin
               line_next_s  = LINE_SE0;
               state_next_s = EOP_SE0_B;
            end
         end

         EOP_SE0_B: begin
            if (shift_en) begin
               line_next_s  = LINE_SE0;
               state_next_s = EOP_J;
            end else begin
               state_next_s = EOP_SE0_B;
            end
         end

         EOP_J: begin
            if (shift_en) begin
               line_next_s  = LINE_J;
               nrzi_next_s  = 1'b1;
               busy_next_s  = 1'b0;
               done_next_s  = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = EOP_J;
            end
         end

         default: begin
            line_next_s  = LINE_J;
            nrzi_next_s  = 1'b1;
            busy_next_s  = 1'b0;
            state_next_s = IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= IDLE;
         shreg_r <= 8'h00;
         ones_r  <= 3'd0;
         nrzi_r  <= 1'b1;
         line_r  <= LINE_J;
         last_r  <= 1'b0;
         busy_r  <= 1'b0;
         ack_r   <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         shreg_r <= shreg_next_s;
         ones_r  <= ones_next_s;
         nrzi_r  <= nrzi_next_s;
         line_r  <= line_next_s;
         last_r  <= last_next_s;
         busy_r  <= busy_next_s;
         ack_r   <= ack_next_s;
         done_r  <= done_next_s;
      end
   end

   assign d_plus   = line_r[1];
   assign d_minus  = line_r[0];
   assign tx_busy  = busy_r;
   assign byte_ack = ack_r;
   assign tx_done  = done_r;

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Serial line encoder directly downstream of `tx_timer` in the bulk-transfer transmit path. It consumes `shift_en` as a once-per-bit-time strobe and serialises a packet onto the USB differential pair: a SYNC byte, the payload bytes LSB first, then EOP. The output is NRZI-encoded with USB bit stuffing. Payload bytes come from the upstream byte source through a simple acknowledge handshake.

## Interface
Parameters:
- none; all constants live in `usb_tx_pkg`

Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `shift_en`  in  1  one-cycle bit-time strobe from `tx_timer`
- `tx_start`  in  1  pulse: begin a packet; honoured only in IDLE
- `tx_data`  in  8  payload byte; held stable from `tx_start`, or from the previous `byte_ack`, until `byte_ack`
- `tx_last`  in  1  qualifies `tx_data` as the final payload byte; sampled with it
- `byte_ack`  out  1  one-cycle pulse: `tx_data`/`tx_last` captured
- `d_plus`  out  1  D+ line, registered
- `d_minus`  out  1  D− line, registered
- `tx_busy`  out  1  high from the cycle after `tx_start` is accepted until `tx_done`
- `tx_done`  out  1  one-cycle pulse at packet completion

## Operation
- Line states:
  - J = (1,0)
  - K = (0,1)
  - SE0 = (0,0)
- Idle drives J. NRZI reference resets to J at every return to IDLE.
- NRZI encoding: bit 0 toggles the line between J and K; bit 1 holds it.
- States: IDLE, SYNC, DATA, EOP_SE0_A, EOP_SE0_B, EOP_J.
- Outputs change only on cycles where `shift_en`=1. Exceptions: `byte_ack`, `tx_done`, and the `tx_busy` rise.
- IDLE + `tx_start`:
  - load shift register with 8'h80
  - clear bit index and ones counter
  - go to SYNC
  - line stays J until the first `shift_en`
- SYNC/DATA on `shift_en`:
  - If ones counter = 6: emit a stuff bit (toggle). Ones counter → 0. Bit index and shift register unchanged.
  - Otherwise: emit shreg[0]. Ones counter increments on 1 and clears on 0. Shift right; bit index +1.
  - On the 8th bit of SYNC, or of a DATA byte with last flag clear: load `tx_data`, latch `tx_last`, pulse `byte_ack` the same cycle, stay in or enter DATA.
  - On the 8th bit of a DATA byte with last flag set: go to EOP_SE0_A.
- EOP_SE0_A on `shift_en`:
  - If ones counter = 6: emit a stuff bit, clear the counter, and stay in EOP_SE0_A.
  - Otherwise: drive SE0 and go to EOP_SE0_B.
- EOP_SE0_B on `shift_en`: drive SE0; go to EOP_J.
- EOP_J on `shift_en`: drive J; go to IDLE.
- Leaving EOP_J: `tx_done` pulses and `tx_busy` falls on the same edge.
- `tx_start` outside IDLE is ignored.
- Missing `tx_start` in IDLE: nothing happens.
- Zero-length payload is not supported; at least one byte is always sent.

## Timing
- Reset (asynchronous, immediate, from any state):
  - `d_plus`=1, `d_minus`=0
  - `tx_busy`=0, `byte_ack`=0, `tx_done`=0
  - state IDLE; counters 0
- A `shift_en` at edge k updates the line at edge k (registered). The new level is visible for the whole bit time.
- `byte_ack` coincides with the edge that emits bit 7 of the previous byte. Upstream has one full bit time to present the next byte.
- A stuff bit consumes one full bit time and delays all later bits by one strobe.
- Packet with N bytes and S stuff bits takes 8+8N+S+3 strobes from start.
- `shift_en` and `tx_start` in the same cycle while in IDLE: only `tx_start` is acted on. The first bit is emitted on the next strobe.

## Structure
- `usb_tx_pkg` contains:
  - state enum `tx_enc_state_t`
  - `SYNC_BYTE`=8'h80
  - `STUFF_LIMIT`=6
  - line-state constants `LINE_J`, `LINE_K`, `LINE_SE0`
- Reuse `flex_counter` (4-bit, rollover 8) for the bit index, enabled on non-stuff strobes.
- The ones counter (3-bit) and the NRZI register stay local.

## Test plan
- Reset asserted mid-DATA → same cycle `d_plus`=1, `d_minus`=0, `tx_busy`=0. The next `tx_start` produces a clean SYNC.
- Single byte 0x00, `tx_last`=1 → line per strobe: K J K J K J K K, J K J K J K J K, SE0 SE0 J. Exactly one `byte_ack`, one `tx_done`, 19 strobes total.
- Single byte 0xFF → after SYNC: five K holds, stuff toggle to J, three J holds, then SE0 SE0 J. 20 strobes.
- Last byte 0xFC → six trailing 1s. A stuff bit is emitted before the first SE0.
- Two bytes 0x12, 0x34 back to back → `byte_ack` pulses on the SYNC bit-7 strobe and the byte-0 bit-7 strobe. Decoded line bits equal 0x12, 0x34 LSB first.
- `tx_start` pulsed during DATA and no `shift_en` for 50 cycles → line and state hold. The second start is ignored and no extra `byte_ack` occurs.
